// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix FSM state type and line-size bound
// for the PS/2 key sequencer.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXTENDED  = 8'hE0;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_BACKSPACE = 8'h66;

    // Set-2 make codes for letters A..Z
    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

    // Line length travels on 5-bit ports, so the buffer can never exceed 31
    localparam int unsigned MAX_CHARS_LIMIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } key_state_t;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 letter make code to upper-case ASCII decode.
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_letter,
    output logic [7:0] ascii
);

    always_comb begin
        is_letter = 1'b1;
        ascii     = '0;
        case (code)
            SC_A: ascii = "A";
            SC_B: ascii = "B";
            SC_C: ascii = "C";
            SC_D: ascii = "D";
            SC_E: ascii = "E";
            SC_F: ascii = "F";
            SC_G: ascii = "G";
            SC_H: ascii = "H";
            SC_I: ascii = "I";
            SC_J: ascii = "J";
            SC_K: ascii = "K";
            SC_L: ascii = "L";
            SC_M: ascii = "M";
            SC_N: ascii = "N";
            SC_O: ascii = "O";
            SC_P: ascii = "P";
            SC_Q: ascii = "Q";
            SC_R: ascii = "R";
            SC_S: ascii = "S";
            SC_T: ascii = "T";
            SC_U: ascii = "U";
            SC_V: ascii = "V";
            SC_W: ascii = "W";
            SC_X: ascii = "X";
            SC_Y: ascii = "Y";
            SC_Z: ascii = "Z";
            default: is_letter = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns PS/2 scan codes into a committed ASCII line with valid/ready handoff.
// Optional KEYSEQ_BACKSPACE_EN enables 0x66 as a delete-newest-char key.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 20,
    parameter int unsigned ERR_W     = 8
) (
    input  logic                   CLK,
    input  logic                   clr,
    input  logic                   code_valid,
    input  logic [7:0]             code,
    input  logic                   code_err,
    output logic                   line_valid,
    input  logic                   line_ready,
    output logic [8*MAX_CHARS-1:0] line_data,
    output logic [4:0]             line_len,
    output logic [4:0]             cur_len,
    output logic                   buf_full,
    output logic [7:0]             last_make,
    output logic [ERR_W-1:0]       err_count
);

    localparam logic [4:0] MAX_LEN = 5'(MAX_CHARS);

    key_state_t             state;
    logic [8*MAX_CHARS-1:0] buf_q;
    logic                   is_letter;
    logic [7:0]             ascii;
    logic [8*MAX_CHARS-1:0] ascii_word;

    ps2_ascii_lut u_lut (
        .code      (code),
        .is_letter (is_letter),
        .ascii     (ascii)
    );

    // Zero-extended char so the shift-in works for any MAX_CHARS, including 1
    always_comb begin
        ascii_word      = '0;
        ascii_word[7:0] = ascii;
    end

    assign buf_full = (cur_len == MAX_LEN);

    always_ff @(posedge CLK) begin
        if (clr) begin
            state      <= ST_IDLE;
            buf_q      <= '0;
            cur_len    <= '0;
            line_valid <= 1'b0;
            line_data  <= '0;
            line_len   <= '0;
            last_make  <= '0;
            err_count  <= '0;
        end else begin
            if (line_valid && line_ready)
                line_valid <= 1'b0;

            if (code_valid) begin
                if (code_err) begin
                    state <= ST_IDLE;
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (code == SC_BREAK) begin
                                state <= ST_BRK;
                            end else if (code == SC_EXTENDED) begin
                                state <= ST_EXT;
                            end else begin
                                last_make <= code;
                                if (is_letter) begin
                                    if (cur_len < MAX_LEN) begin
                                        buf_q   <= (buf_q << 8) | ascii_word;
                                        cur_len <= cur_len + 5'd1;
                                    end
                                end else if (code == SC_ENTER) begin
                                    // Overrides the handshake clear above on a same-cycle accept
                                    if (!line_valid || line_ready) begin
                                        line_data  <= buf_q;
                                        line_len   <= cur_len;
                                        line_valid <= 1'b1;
                                        buf_q      <= '0;
                                        cur_len    <= '0;
                                    end
                                end
`ifdef KEYSEQ_BACKSPACE_EN
                                else if (code == SC_BACKSPACE) begin
                                    if (cur_len != 5'd0) begin
                                        buf_q   <= buf_q >> 8;
                                        cur_len <= cur_len - 5'd1;
                                    end
                                end
`else
`endif
                            end
                        end
                        ST_BRK: state <= ST_IDLE;
                        ST_EXT: begin
                            if (code == SC_BREAK)
                                state <= ST_EXT_BRK;
                            else
                                state <= ST_IDLE;
                        end
                        ST_EXT_BRK: state <= ST_IDLE;
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
